// File: rtl/mux_pipe_pkg.sv
// Shared sizing helpers for the pipelined 2**ADDR_W:1 multiplexer.
package mux_pipe_pkg;

  localparam int MUX_N_DEFAULT      = 4;
  localparam int MUX_ADDR_W_DEFAULT = 9;

  typedef enum logic {
    STAGE_COMB = 1'b0,
    STAGE_REG  = 1'b1
  } stage_kind_e;

  function automatic int stages(input int addr_w);
    return (addr_w + 1) / 2;
  endfunction

  // Entries remaining after stage k; k = -1 gives the raw input count.
  function automatic int stage_width(input int addr_w, input int k);
    int rem;
    rem = addr_w - 2 * (k + 1);
    if (rem < 0) rem = 0;
    return 1 << rem;
  endfunction

  // Entry offset of tree level lvl inside the flattened word bus (level 0 = inputs).
  function automatic int level_offset(input int addr_w, input int lvl);
    int off;
    off = 0;
    for (int l = 0; l < lvl; l++) off += stage_width(addr_w, l - 1);
    return off;
  endfunction

endpackage

// File: rtl/mux_pipe_stage.sv
// One radix-4 (or radix-2) select reduction with an optional register stage
// and its valid/advance handshake logic.
module mux_pipe_stage
  import mux_pipe_pkg::*;
#(
  parameter int          N       = 4,
  parameter int          IN_CNT  = 4,
  parameter int          ADDR_W  = 2,
  parameter int          SEL_LSB = 0,
  parameter int          RLOG    = 2,
  parameter stage_kind_e KIND    = STAGE_REG,
  parameter bit          LAST    = 1'b0
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          vld_i,
  input  logic [IN_CNT*N-1:0]           data_i,
  input  logic [ADDR_W-1:0]             sel_i,
  input  logic                          adv_i,
  output logic                          vld_o,
  output logic [(IN_CNT>>RLOG)*N-1:0]   data_o,
  output logic [ADDR_W-1:0]             sel_o,
  output logic                          adv_o
);

  localparam int R       = 1 << RLOG;
  localparam int OUT_CNT = IN_CNT >> RLOG;

  logic [OUT_CNT*N-1:0] red;

  always_comb begin
    red = '0;
    for (int j = 0; j < OUT_CNT; j++) begin
      red[j*N +: N] = data_i[(j*R + int'(sel_i[SEL_LSB +: RLOG]))*N +: N];
    end
  end

  if (KIND == STAGE_REG) begin : g_reg
    logic                 vld_p0;
    logic [OUT_CNT*N-1:0] dat_p0;
    logic [ADDR_W-1:0]    sel_p0;
    logic                 adv;
    logic                 load;

    // A held word may only be replaced when it moves on in the same cycle.
    assign adv  = !vld_p0 || adv_i;
    assign load = adv && vld_i;

    // ---- stage register p0 ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) vld_p0 <= 1'b0;
      else if (adv) vld_p0 <= vld_i;
    end

    always_ff @(posedge clk_i) begin
      if (load) sel_p0 <= sel_i;
    end

    if (LAST) begin : g_dat_rst
      // The output word is visible at the port, so it clears with the valid bit.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) dat_p0 <= '0;
        else if (load) dat_p0 <= red;
      end
    end else begin : g_dat
      always_ff @(posedge clk_i) begin
        if (load) dat_p0 <= red;
      end
    end

    assign vld_o  = vld_p0;
    assign data_o = dat_p0;
    assign sel_o  = sel_p0;
    assign adv_o  = adv;
  end else begin : g_comb
    assign vld_o  = vld_i;
    assign data_o = red;
    assign sel_o  = sel_i;
    assign adv_o  = adv_i;
  end

endmodule

// File: rtl/mux_pipe_n.sv
// Pipelined, flow-controlled 2**ADDR_W:1 mux built from a chain of radix-4 stages.
// Define MUX_PIPE_REG_EN to register every stage; otherwise only the output is registered.
module mux_pipe_n
  import mux_pipe_pkg::*;
#(
  parameter int N      = MUX_N_DEFAULT,
  parameter int ADDR_W = MUX_ADDR_W_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [N-1:0]      data_i [0:2**ADDR_W-1],
  input  logic [ADDR_W-1:0] sel,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [N-1:0]      data_o,
  output logic              valid_o,
  input  logic              ready_i
);

  localparam int M        = 2 ** ADDR_W;
  localparam int S        = stages(ADDR_W);
  localparam int TOT      = level_offset(ADDR_W, S + 1);
  localparam int LAST_OFF = level_offset(ADDR_W, S);

`ifdef MUX_PIPE_REG_EN
  localparam bit REG_EN = 1'b1;
`else
  localparam bit REG_EN = 1'b0;
`endif

  // All tree levels packed back to back: level 0 is the input vector.
  logic [TOT*N-1:0]  bus;
  logic              vld     [0:S];
  logic              adv     [0:S];
  logic [ADDR_W-1:0] sel_bus [0:S];

  for (genvar i = 0; i < M; i++) begin : g_in
    assign bus[i*N +: N] = data_i[i];
  end

  assign vld[0]     = valid_i;
  assign sel_bus[0] = sel;
  assign adv[S]     = ready_i;

  for (genvar k = 0; k < S; k++) begin : g_stage
    localparam int          IN_CNT  = stage_width(ADDR_W, k - 1);
    localparam int          OUT_CNT = stage_width(ADDR_W, k);
    localparam int          IN_OFF  = level_offset(ADDR_W, k);
    localparam int          OUT_OFF = level_offset(ADDR_W, k + 1);
    localparam int          RLOG    = (2 * k + 1 < ADDR_W) ? 2 : 1;
    localparam stage_kind_e KIND    = (REG_EN || k == S - 1) ? STAGE_REG : STAGE_COMB;

    mux_pipe_stage #(
      .N       (N),
      .IN_CNT  (IN_CNT),
      .ADDR_W  (ADDR_W),
      .SEL_LSB (2 * k),
      .RLOG    (RLOG),
      .KIND    (KIND),
      .LAST    (k == S - 1)
    ) u_stage (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .vld_i  (vld[k]),
      .data_i (bus[IN_OFF*N +: IN_CNT*N]),
      .sel_i  (sel_bus[k]),
      .adv_i  (adv[k+1]),
      .vld_o  (vld[k+1]),
      .data_o (bus[OUT_OFF*N +: OUT_CNT*N]),
      .sel_o  (sel_bus[k+1]),
      .adv_o  (adv[k])
    );
  end

  assign ready_o = adv[0];
  assign valid_o = vld[S];
  assign data_o  = bus[LAST_OFF*N +: N];

endmodule

// File: tb/tb_mux_pipe_n.sv
// Directed bench for mux_pipe_n: default 512:1 x4 instance plus an 8:1 x8 instance.
module tb_mux_pipe_n;

`ifdef MUX_PIPE_REG_EN
  localparam int LAT   = 5;
  localparam int CAP   = 5;
  localparam int LAT_B = 2;
`else
  localparam int LAT   = 1;
  localparam int CAP   = 1;
  localparam int LAT_B = 1;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;

  logic [3:0] data_a [0:511];
  logic [8:0] sel;
  logic       valid_i, ready_i;
  logic       ready_o, valid_o;
  logic [3:0] data_o;

  logic [7:0] data_b [0:7];
  logic [2:0] sel_b;
  logic       valid_b, ready_b;
  logic       ready_ob, valid_ob;
  logic [7:0] data_ob;

  int         checks   = 0;
  int         failures = 0;
  logic [3:0] sb_q [$];

  mux_pipe_n #(.N(4), .ADDR_W(9)) u_dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .data_i  (data_a),
    .sel     (sel),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .valid_o (valid_o),
    .ready_i (ready_i)
  );

  mux_pipe_n #(.N(8), .ADDR_W(3)) u_dut_odd (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .data_i  (data_b),
    .sel     (sel_b),
    .valid_i (valid_b),
    .ready_o (ready_ob),
    .data_o  (data_ob),
    .valid_o (valid_ob),
    .ready_i (ready_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [8:0] s, input logic r);
    valid_i = v;
    sel     = s;
    ready_i = r;
  endtask

  // Scoreboard the handshakes of the current cycle, then advance one clock.
  task automatic tick();
    logic [3:0] e;
    #1;
    if (valid_o && ready_i) begin
      check("sb_pending", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("sb_data", 32'(data_o), 32'(e));
      end
    end
    if (valid_i && ready_o) sb_q.push_back(sel[3:0]);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] s1_exp [0:2];
    int         nxt;
    int         acc_cnt;
    logic       exp_v;

    s1_exp[0] = 4'd5;
    s1_exp[1] = 4'd0;
    s1_exp[2] = 4'd15;
    for (int k = 0; k < 512; k++) data_a[k] = 4'(k);
    for (int k = 0; k < 8; k++) data_b[k] = 8'hA0 + 8'(k);
    drive(1'b0, 9'd0, 1'b0);
    valid_b = 1'b0;
    sel_b   = 3'd0;
    ready_b = 1'b0;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_data", 32'(data_o), 32'd0);
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_valid_b", 32'(valid_ob), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Ordered basic flow
    drive(1'b1, 9'h1A5, 1'b1);
    for (int cyc = 0; cyc < LAT + 4; cyc++) begin
      if (cyc > 0) begin
        exp_v = (cyc >= LAT) && (cyc < LAT + 3);
        check("s1_valid", 32'(valid_o), 32'(exp_v));
        if (exp_v) check("s1_data", 32'(data_o), 32'(s1_exp[cyc-LAT]));
      end
      tick();
      if (cyc == 0) drive(1'b1, 9'h000, 1'b1);
      else if (cyc == 1) drive(1'b1, 9'h1FF, 1'b1);
      else drive(1'b0, 9'd0, 1'b1);
    end
    check("s1_empty", 32'(sb_q.size()), 32'd0);

    // Backpressure
    nxt = 0;
    acc_cnt = 0;
    drive(1'b1, 9'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      sel = 9'(nxt);
      #1;
      if (ready_o) begin
        acc_cnt++;
        nxt++;
      end
      tick();
    end
    sel = 9'(nxt);
    #1;
    check("s2_accepts", 32'(acc_cnt), 32'(CAP));
    check("s2_full", 32'(ready_o), 32'd0);
    ready_i = 1'b1;
    #1;
    check("s2_shift", 32'(ready_o), 32'd1);
    tick();
    drive(1'b0, 9'd0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      if (sb_q.size() != 0) tick();
    end
    check("s2_drain", 32'(sb_q.size()), 32'd0);
    check("s2_idle", 32'(valid_o), 32'd0);

    // Bubble collapse
    drive(1'b1, 9'd3, 1'b0);
    tick();
    drive(1'b0, 9'd0, 1'b0);
    repeat (10) tick();
    drive(1'b1, 9'd7, 1'b0);
    #1;
    check("s3_ready", 32'(ready_o), 32'(CAP > 1));
    if (ready_o) begin
      tick();
      drive(1'b0, 9'd0, 1'b0);
      repeat (4) tick();
    end
    ready_i = 1'b1;
    #1;
    check("s3_first_v", 32'(valid_o), 32'd1);
    check("s3_first_d", 32'(data_o), 32'd3);
    tick();
    drive(1'b0, 9'd0, 1'b1);
    check("s3_second_v", 32'(valid_o), 32'd1);
    check("s3_second_d", 32'(data_o), 32'd7);
    tick();
    check("s3_after", 32'(valid_o), 32'd0);

    // Reset mid-flight
    drive(1'b1, 9'd1, 1'b1);
    tick();
    drive(1'b1, 9'd2, 1'b1);
    tick();
    drive(1'b1, 9'd3, 1'b1);
    tick();
    drive(1'b0, 9'd0, 1'b0);
    repeat (4) tick();
    check("s4_pre_valid", 32'(valid_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check("s4_rst_valid", 32'(valid_o), 32'd0);
    check("s4_rst_data", 32'(data_o), 32'd0);
    check("s4_rst_ready", 32'(ready_o), 32'd1);
    sb_q.delete();
    drive(1'b0, 9'd0, 1'b1);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("s4_no_stale", 32'(valid_o), 32'd0);
    end
    check("s4_ready", 32'(ready_o), 32'd1);

    // Odd width: 8:1 of bytes
    valid_b = 1'b1;
    sel_b   = 3'd7;
    ready_b = 1'b1;
    #1;
    check("s5_ready", 32'(ready_ob), 32'd1);
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(posedge clk);
      #1;
      valid_b = 1'b0;
      check("s5_valid", 32'(valid_ob), 32'(cyc == LAT_B));
      if (cyc == LAT_B) check("s5_data", 32'(data_ob), 32'h0000_00A7);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
